// File: rtl/axi_slave_resp_pop_pkg.sv
// Shared response encodings and FSM state types for the AXI slave
// response pop logic (B path and R burst path).
package axi_slave_package;

  localparam int unsigned RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic {
    B_IDLE  = 1'b0,
    B_VALID = 1'b1
  } b_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_BEAT  = 2'b01,
    R_STALL = 2'b10
  } r_state_e;

endpackage

// File: rtl/axi_slave_resp_pop_if.sv
// AXI B and R response channels; the slave modport drives responses,
// the master modport drives the ready signals.
interface axi_slave_resp_pop_if #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 256
);
  import axi_slave_package::*;

  logic [ID_WIDTH-1:0]   BID;
  logic [RESP_W-1:0]     BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [RESP_W-1:0]     RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    output BID, BRESP, BVALID,
    input  BREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    input  BID, BRESP, BVALID,
    output BREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_r_burst_pop.sv
// R channel burst sequencer: pops a header plus its data beats from two
// FWFT FIFOs and presents them as an AXI read burst from registers.
module axi_r_burst_pop
  import axi_slave_package::*;
#(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_hdr_empty,
  input  logic [ID_WIDTH+LEN_WIDTH+1:0]     i_hdr_rdata,
  output logic                              o_hdr_rd_en,
  input  logic                              i_data_empty,
  input  logic [DATA_WIDTH-1:0]             i_data_rdata,
  output logic                              o_data_rd_en,
  input  logic                              i_rready,
  output logic [ID_WIDTH-1:0]               o_rid,
  output logic [DATA_WIDTH-1:0]             o_rdata,
  output logic [RESP_W-1:0]                 o_rresp,
  output logic                              o_rlast,
  output logic                              o_rvalid
);

  r_state_e              r_state;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [RESP_W-1:0]     r_rresp;
  logic                  r_rlast;
  logic                  r_rvalid;

  logic                  w_hs;
  logic                  w_start_ok;
  logic                  w_start;
  logic                  w_next_beat;
  logic [ID_WIDTH-1:0]   w_hdr_id;
  logic [LEN_WIDTH-1:0]  w_hdr_len;
  logic [RESP_W-1:0]     w_hdr_resp;
  logic [LEN_WIDTH-1:0]  w_cnt_dec;

  assign w_hdr_id   = i_hdr_rdata[ID_WIDTH+LEN_WIDTH+1:LEN_WIDTH+2];
  assign w_hdr_len  = i_hdr_rdata[LEN_WIDTH+1:2];
  assign w_hdr_resp = i_hdr_rdata[1:0];

  assign w_hs       = r_rvalid & i_rready;
  // A burst only starts once its first beat is present, so RVALID never rises without data.
  assign w_start_ok = ~i_hdr_empty & ~i_data_empty;
  assign w_cnt_dec  = r_cnt - LEN_WIDTH'(1);

  always_comb begin
    w_start     = 1'b0;
    w_next_beat = 1'b0;
    case (r_state)
      R_IDLE:  w_start = w_start_ok;
      R_BEAT: begin
        if (w_hs) begin
          if (r_rlast) w_start     = w_start_ok;
          else         w_next_beat = ~i_data_empty;
        end
      end
      R_STALL: w_next_beat = ~i_data_empty;
      default: ;
    endcase
  end

  // Gated by reset so no FIFO is popped while the FSM is held in reset.
  assign o_hdr_rd_en  = w_start & i_rst_n;
  assign o_data_rd_en = (w_start | w_next_beat) & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (w_start) begin
            r_rid    <= w_hdr_id;
            r_rresp  <= w_hdr_resp;
            r_cnt    <= w_hdr_len;
            r_rlast  <= (w_hdr_len == '0);
            r_rdata  <= i_data_rdata;
            r_rvalid <= 1'b1;
            r_state  <= R_BEAT;
          end
        end
        R_BEAT: begin
          if (w_hs) begin
            if (w_start) begin
              r_rid    <= w_hdr_id;
              r_rresp  <= w_hdr_resp;
              r_cnt    <= w_hdr_len;
              r_rlast  <= (w_hdr_len == '0);
              r_rdata  <= i_data_rdata;
            end else if (w_next_beat) begin
              r_rdata  <= i_data_rdata;
              r_cnt    <= w_cnt_dec;
              r_rlast  <= (w_cnt_dec == '0);
            end else if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= R_IDLE;
            end else begin
              r_rvalid <= 1'b0;
              r_state  <= R_STALL;
            end
          end
        end
        R_STALL: begin
          if (w_next_beat) begin
            r_rdata  <= i_data_rdata;
            r_cnt    <= w_cnt_dec;
            r_rlast  <= (w_cnt_dec == '0);
            r_rvalid <= 1'b1;
            r_state  <= R_BEAT;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign o_rid    = r_rid;
  assign o_rdata  = r_rdata;
  assign o_rresp  = r_rresp;
  assign o_rlast  = r_rlast;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/axi_slave_resp_pop.sv
// Pops write responses and read bursts from FWFT FIFOs onto AXI B and R;
// the B path is inline, the R path lives in axi_r_burst_pop.
module axi_slave_resp_pop
  import axi_slave_package::*;
#(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          b_empty,
  input  logic [ID_WIDTH+1:0]           b_rdata,
  output logic                          b_rd_en,
  input  logic                          r_hdr_empty,
  input  logic [ID_WIDTH+LEN_WIDTH+1:0] r_hdr_rdata,
  output logic                          r_hdr_rd_en,
  input  logic                          r_data_empty,
  input  logic [DATA_WIDTH-1:0]         r_data_rdata,
  output logic                          r_data_rd_en,
  axi_slave_resp_pop_if.slave           axi
);

  b_state_e            r_b_state;
  logic [ID_WIDTH-1:0] r_bid;
  logic [RESP_W-1:0]   r_bresp;
  logic                r_bvalid;
  logic                w_b_hs;
  logic                w_b_pop;

  assign w_b_hs = r_bvalid & axi.BREADY;

  always_comb begin
    w_b_pop = 1'b0;
    case (r_b_state)
      B_IDLE:  w_b_pop = ~b_empty;
      B_VALID: w_b_pop = w_b_hs & ~b_empty;
      default: w_b_pop = 1'b0;
    endcase
  end

  assign b_rd_en = w_b_pop & ARESETn;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_b_state <= B_IDLE;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_b_state)
        B_IDLE: begin
          if (w_b_pop) begin
            r_bid     <= b_rdata[ID_WIDTH+1:2];
            r_bresp   <= b_rdata[1:0];
            r_bvalid  <= 1'b1;
            r_b_state <= B_VALID;
          end
        end
        B_VALID: begin
          // Reload on the handshake cycle to sustain one response per clock.
          if (w_b_hs) begin
            if (w_b_pop) begin
              r_bid   <= b_rdata[ID_WIDTH+1:2];
              r_bresp <= b_rdata[1:0];
            end else begin
              r_bvalid  <= 1'b0;
              r_b_state <= B_IDLE;
            end
          end
        end
        default: r_b_state <= B_IDLE;
      endcase
    end
  end

  assign axi.BID    = r_bid;
  assign axi.BRESP  = r_bresp;
  assign axi.BVALID = r_bvalid;

  logic [ID_WIDTH-1:0]   w_rid;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [RESP_W-1:0]     w_rresp;
  logic                  w_rlast;
  logic                  w_rvalid;

  axi_r_burst_pop #(
    .ID_WIDTH  (ID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_r_pop (
    .i_clk       (ACLK),
    .i_rst_n     (ARESETn),
    .i_hdr_empty (r_hdr_empty),
    .i_hdr_rdata (r_hdr_rdata),
    .o_hdr_rd_en (r_hdr_rd_en),
    .i_data_empty(r_data_empty),
    .i_data_rdata(r_data_rdata),
    .o_data_rd_en(r_data_rd_en),
    .i_rready    (axi.RREADY),
    .o_rid       (w_rid),
    .o_rdata     (w_rdata),
    .o_rresp     (w_rresp),
    .o_rlast     (w_rlast),
    .o_rvalid    (w_rvalid)
  );

  assign axi.RID    = w_rid;
  assign axi.RDATA  = w_rdata;
  assign axi.RRESP  = w_rresp;
  assign axi.RLAST  = w_rlast;
  assign axi.RVALID = w_rvalid;

endmodule

// File: tb/tb_axi_slave_resp_pop.sv
// Scoreboard bench: FWFT FIFO models feed the DUT, expected B responses and
// R beats are queued at push time and checked by an independent monitor.
module tb_axi_slave_resp_pop;
  import axi_slave_package::*;

  localparam int unsigned IW = 8;
  localparam int unsigned DW = 256;
  localparam int unsigned LW = 8;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             b_empty, b_rd_en;
  logic [IW+1:0]    b_rdata;
  logic             r_hdr_empty, r_hdr_rd_en;
  logic [IW+LW+1:0] r_hdr_rdata;
  logic             r_data_empty, r_data_rd_en;
  logic [DW-1:0]    r_data_rdata;

  axi_slave_resp_pop_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) axi ();

  axi_slave_resp_pop #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .b_empty     (b_empty),
    .b_rdata     (b_rdata),
    .b_rd_en     (b_rd_en),
    .r_hdr_empty (r_hdr_empty),
    .r_hdr_rdata (r_hdr_rdata),
    .r_hdr_rd_en (r_hdr_rd_en),
    .r_data_empty(r_data_empty),
    .r_data_rdata(r_data_rdata),
    .r_data_rd_en(r_data_rd_en),
    .axi         (axi)
  );

  logic [IW+1:0]    bq[$];
  logic [IW+LW+1:0] hq[$];
  logic [DW-1:0]    dq[$];
  logic [DW-1:0]    pend_d[$];
  logic [IW+1:0]    exp_b[$];
  rexp_t            exp_r[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
    bq.push_back({id, resp});
    exp_b.push_back({id, resp});
  endtask

  // Expected beats follow directly from the burst rule: len+1 beats, last on the final one.
  task automatic push_burst(input logic [IW-1:0] id, input int unsigned len, input logic [1:0] resp);
    rexp_t         e;
    logic [DW-1:0] d;
    hq.push_back({id, LW'(len), resp});
    for (int unsigned i = 0; i <= len; i++) begin
      for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom;
      pend_d.push_back(d);
      e.id = id; e.data = d; e.resp = resp; e.last = (i == len);
      exp_r.push_back(e);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n && pend_d.size() > 0; i++) dq.push_back(pend_d.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // FIFO model: present heads after stimulus, sample pops before the edge, apply after it.
  logic             pop_b, pop_h, pop_d;
  logic [IW+1:0]    tmp_b;
  logic [IW+LW+1:0] tmp_h;
  logic [DW-1:0]    tmp_d;
  initial begin
    b_empty = 1'b1; b_rdata = '0;
    r_hdr_empty = 1'b1; r_hdr_rdata = '0;
    r_data_empty = 1'b1; r_data_rdata = '0;
    forever begin
      @(negedge clk); #1;
      b_empty      = (bq.size() == 0);
      b_rdata      = b_empty ? '0 : bq[0];
      r_hdr_empty  = (hq.size() == 0);
      r_hdr_rdata  = r_hdr_empty ? '0 : hq[0];
      r_data_empty = (dq.size() == 0);
      r_data_rdata = r_data_empty ? '0 : dq[0];
      #1;
      pop_b = b_rd_en; pop_h = r_hdr_rd_en; pop_d = r_data_rd_en;
      @(posedge clk); #1;
      if (rst_n) begin
        if (pop_b && bq.size() > 0) tmp_b = bq.pop_front();
        if (pop_h && hq.size() > 0) tmp_h = hq.pop_front();
        if (pop_d && dq.size() > 0) tmp_d = dq.pop_front();
      end
    end
  end

  // Monitor: compares every handshake against the scoreboard queues.
  logic [IW+1:0] mb;
  rexp_t         mr;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        chk("b_rd_en_while_empty", DW'(b_rd_en & b_empty), '0);
        chk("r_hdr_rd_en_while_empty", DW'(r_hdr_rd_en & r_hdr_empty), '0);
        chk("r_data_rd_en_while_empty", DW'(r_data_rd_en & r_data_empty), '0);
        if (axi.BVALID && axi.BREADY) begin
          if (exp_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected: got id %0h, expected no response", axi.BID);
          end else begin
            mb = exp_b.pop_front();
            chk("b_id", DW'(axi.BID), DW'(mb[IW+1:2]));
            chk("b_resp", DW'(axi.BRESP), DW'(mb[1:0]));
          end
        end
        if (axi.RVALID && axi.RREADY) begin
          if (exp_r.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected: got id %0h, expected no beat", axi.RID);
          end else begin
            mr = exp_r.pop_front();
            chk("r_id", DW'(axi.RID), DW'(mr.id));
            chk("r_data", axi.RDATA, mr.data);
            chk("r_resp", DW'(axi.RRESP), DW'(mr.resp));
            chk("r_last", DW'(axi.RLAST), DW'(mr.last));
          end
        end
      end
    end
  end

  task automatic drain(input int max);
    int n = 0;
    axi.BREADY = 1'b1;
    axi.RREADY = 1'b1;
    while ((exp_b.size() != 0 || exp_r.size() != 0 || bq.size() != 0 || hq.size() != 0 ||
            dq.size() != 0 || axi.BVALID || axi.RVALID) && n < max) begin
      feed(8);
      tick();
      n++;
    end
    chk("drain_done", DW'(n < max), DW'(1));
  endtask

  initial begin
    axi.BREADY = 1'b0;
    axi.RREADY = 1'b0;
    rst_n = 1'b0;
    // Reset with a non-empty FIFO: nothing may pop, all outputs zero.
    bq.push_back({8'h44, OKAY});
    repeat (2) tick();
    #3;
    chk("rst_b_rd_en", DW'(b_rd_en), '0);
    chk("rst_bvalid", DW'(axi.BVALID), '0);
    chk("rst_bid", DW'(axi.BID), '0);
    chk("rst_rvalid", DW'(axi.RVALID), '0);
    chk("rst_rlast", DW'(axi.RLAST), '0);
    chk("rst_rdata", axi.RDATA, '0);
    tick();
    bq.delete();
    rst_n = 1'b1;

    // B back-to-back
    tick();
    axi.BREADY = 1'b1;
    push_b(8'd1, OKAY); push_b(8'd2, OKAY); push_b(8'd3, OKAY);
    #3 chk("b2b_bvalid_lat", DW'(axi.BVALID), '0);
    for (int k = 1; k <= 3; k++) begin
      tick(); #3;
      chk("b2b_bvalid", DW'(axi.BVALID), DW'(1));
      chk("b2b_bid", DW'(axi.BID), DW'(k));
    end
    tick(); #3 chk("b2b_bvalid_end", DW'(axi.BVALID), '0);

    // B backpressure
    tick();
    axi.BREADY = 1'b0;
    push_b(8'h11, SLVERR); push_b(8'h12, DECERR);
    for (int k = 0; k < 5; k++) begin
      tick(); #3;
      chk("bp_bvalid", DW'(axi.BVALID), DW'(1));
      chk("bp_bid", DW'(axi.BID), DW'(8'h11));
      chk("bp_bresp", DW'(axi.BRESP), DW'(SLVERR));
      chk("bp_b_rd_en", DW'(b_rd_en), '0);
    end
    tick();
    drain(50);

    // R single burst, len 3
    tick();
    axi.RREADY = 1'b1;
    push_burst(8'd5, 3, OKAY); feed(4);
    #3 chk("burst_rvalid_lat", DW'(axi.RVALID), '0);
    for (int k = 0; k < 4; k++) begin
      tick(); #3;
      chk("burst_rvalid", DW'(axi.RVALID), DW'(1));
      chk("burst_rlast", DW'(axi.RLAST), DW'(k == 3));
      chk("burst_rid", DW'(axi.RID), DW'(5));
    end
    tick(); #3 chk("burst_rvalid_end", DW'(axi.RVALID), '0);

    // R starvation: second beat late
    tick();
    push_burst(8'd9, 2, EXOKAY); feed(1);
    tick(); #3;
    chk("starve_beat0_valid", DW'(axi.RVALID), DW'(1));
    chk("starve_beat0_last", DW'(axi.RLAST), '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) feed(2);
      #3 chk("starve_gap_rvalid", DW'(axi.RVALID), '0);
    end
    tick(); #3;
    chk("starve_beat1_valid", DW'(axi.RVALID), DW'(1));
    chk("starve_beat1_last", DW'(axi.RLAST), '0);
    tick(); #3;
    chk("starve_beat2_valid", DW'(axi.RVALID), DW'(1));
    chk("starve_beat2_last", DW'(axi.RLAST), DW'(1));
    tick(); #3 chk("starve_end_rvalid", DW'(axi.RVALID), '0);

    // Back-to-back bursts, zero bubble
    tick();
    push_burst(8'd7, 0, EXOKAY); push_burst(8'd8, 1, OKAY); feed(3);
    tick(); #3;
    chk("b2b_r1_valid", DW'(axi.RVALID), DW'(1));
    chk("b2b_r1_last", DW'(axi.RLAST), DW'(1));
    chk("b2b_r1_id", DW'(axi.RID), DW'(7));
    tick(); #3;
    chk("b2b_r2_valid", DW'(axi.RVALID), DW'(1));
    chk("b2b_r2_last", DW'(axi.RLAST), '0);
    chk("b2b_r2_id", DW'(axi.RID), DW'(8));
    tick(); #3;
    chk("b2b_r3_valid", DW'(axi.RVALID), DW'(1));
    chk("b2b_r3_last", DW'(axi.RLAST), DW'(1));
    tick(); #3 chk("b2b_r_end", DW'(axi.RVALID), '0);

    // Reset during beat 2 of a len-7 burst
    tick();
    push_burst(8'd3, 7, OKAY); feed(8);
    tick(); #3 chk("mid_beat1_valid", DW'(axi.RVALID), DW'(1));
    tick(); #3 chk("mid_beat2_valid", DW'(axi.RVALID), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", DW'(axi.RVALID), '0);
    chk("mid_rst_rlast", DW'(axi.RLAST), '0);
    chk("mid_rst_rid", DW'(axi.RID), '0);
    chk("mid_rst_rdata", axi.RDATA, '0);
    chk("mid_rst_data_rd_en", DW'(r_data_rd_en), '0);
    hq.delete(); dq.delete(); pend_d.delete(); exp_r.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick(); #3;
    chk("mid_post_state", DW'(dut.u_r_pop.r_state), DW'(R_IDLE));
    chk("mid_post_rvalid", DW'(axi.RVALID), '0);
    tick();
    push_burst(8'h21, 1, SLVERR); feed(2);
    tick(); #3;
    chk("mid_restart_valid", DW'(axi.RVALID), DW'(1));
    chk("mid_restart_id", DW'(axi.RID), DW'(8'h21));
    drain(50);

    // Randomized traffic with random backpressure and data trickle
    for (int c = 0; c < 600; c++) begin
      tick();
      axi.BREADY = ($urandom_range(0, 3) != 0);
      axi.RREADY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && bq.size() < 6)
        push_b(IW'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0 && hq.size() < 4)
        push_burst(IW'($urandom_range(0, 255)), $urandom_range(0, 5), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) != 0) feed(1);
    end
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_slave_resp_pop.md
AXI_SLAVE_RESP_POP -- requirements
Module: axi_slave_resp_pop

Interface
REQ-001 Parameters SHALL be, one per line: ID_WIDTH, default 8, AXI ID width; DATA_WIDTH, default 256, RDATA width; LEN_WIDTH, default 8, burst length field (AXI LEN, beats-1).
REQ-002 ACLK  input  1  clock; one clock domain, all logic rising-edge.
REQ-003 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 b_empty  input  1  B-response FIFO empty; FIFO is first-word-fall-through.
REQ-005 b_rdata  input  ID_WIDTH+2  {id, resp} at B FIFO head, valid when b_empty=0.
REQ-006 b_rd_en  output  1  pops B FIFO head this cycle.
REQ-007 r_hdr_empty  input  1  R-header FIFO empty (FWFT).
REQ-008 r_hdr_rdata  input  ID_WIDTH+LEN_WIDTH+2  {id, len, resp} at header head.
REQ-009 r_hdr_rd_en  output  1  pops header FIFO.
REQ-010 r_data_empty  input  1  R-data FIFO empty (FWFT).
REQ-011 r_data_rdata  input  DATA_WIDTH  data beat at data FIFO head.
REQ-012 r_data_rd_en  output  1  pops data FIFO.
REQ-013 BID/BRESP/BVALID  output  ID_WIDTH/2/1  AXI B channel; BREADY  input  1.
REQ-014 RID/RDATA/RRESP/RLAST/RVALID  output  ID_WIDTH/DATA_WIDTH/2/1/1  AXI R channel; RREADY  input  1.
REQ-015 All AXI outputs SHALL be driven directly from flops.

Function
REQ-016 B and R paths SHALL be independent FSMs; neither SHALL stall the other.
REQ-017 B FSM states: B_IDLE, B_VALID.
REQ-018 B_IDLE with b_empty=0: assert b_rd_en, load BID/BRESP from b_rdata, go B_VALID; BVALID=1 the next cycle (latency 1).
REQ-019 B_VALID: BVALID, BID, BRESP SHALL remain stable until BVALID&&BREADY.
REQ-020 On B handshake with b_empty=0: pop and load next entry in same cycle, stay B_VALID (one response per cycle sustained); with b_empty=1: BVALID=0, go B_IDLE.
REQ-021 R FSM states: R_IDLE, R_BEAT, R_STALL.
REQ-022 R_IDLE with r_hdr_empty=0 and r_data_empty=0: pop header and first beat in same cycle, load RID/RRESP, beat counter=len, RLAST=(len==0), RVALID=1 next cycle, go R_BEAT.
REQ-023 R_IDLE with header present but data empty: no pop, remain R_IDLE.
REQ-024 R_BEAT: RDATA/RID/RRESP/RLAST stable until RVALID&&RREADY.
REQ-025 R_BEAT handshake, counter>0, r_data_empty=0: pop next beat, decrement counter, RLAST=(counter-1==0), stay R_BEAT.
REQ-026 R_BEAT handshake, counter>0, r_data_empty=1: RVALID=0, go R_STALL; R_STALL pops first available beat, RVALID=1, return R_BEAT.
REQ-027 R_BEAT handshake with RLAST=1: if next header and data available, pop both and start next burst in same cycle (zero bubble); else RVALID=0, RLAST=0, go R_IDLE.
REQ-028 Burst SHALL emit exactly len+1 beats; RLAST asserted on final beat only.
REQ-029 Counter width SHALL be LEN_WIDTH; no wrap, since counter never decrements below 0.
REQ-030 b_rd_en/r_hdr_rd_en/r_data_rd_en SHALL never assert when the corresponding empty=1.

Reset
REQ-031 ARESETn low SHALL immediately force B_IDLE, R_IDLE, counter=0, all valids/RLAST=0, BID/BRESP/RID/RRESP/RDATA=0, all rd_en=0.
REQ-032 Reset mid-burst SHALL discard the partial burst; FIFO flush is the upstream's responsibility.

Structure
REQ-033 axi_slave_package SHALL hold resp encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the B/R state enums.
REQ-034 R path SHALL be one sub-module, axi_r_burst_pop; B path SHALL be inline in the top.

Verification
REQ-035 B back-to-back: 3 entries {id 1,2,3, OKAY}, BREADY=1 -> BVALID high 3 consecutive cycles, BID 1,2,3, then 0.
REQ-036 B backpressure: BREADY=0 for 5 cycles -> BID/BRESP unchanged, b_rd_en=0 throughout.
REQ-037 R burst: header {id 5, len 3, OKAY}, 4 beats A0..A3, RREADY=1 -> 4 beats, RLAST only on A3, RID=5 all beats.
REQ-038 R starvation: len 2, second beat arrives 4 cycles late -> RVALID=0 during gap, resumes with correct data, RLAST on third beat.
REQ-039 Back-to-back bursts: len 0 (id 7) then len 1 (id 8), all data present -> 3 consecutive RVALID cycles, RLAST on beats 1 and 3.
REQ-040 Reset mid-burst: ARESETn low during beat 2 of len 7 -> same-cycle RVALID=0, RLAST=0, FSM R_IDLE after release.
